multiplier_core: RTL and testbench

//  Sequential signed 32x32 integer multiplier for the processor's multdiv unit.
//  It uses radix-4 Booth recoding with 16 iteration cycles.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/booth_r4_encoder.sv | 22 ++
 rtl/multiplier_core.sv | 136 +++++++++++++
 tb/tb_multiplier_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mult_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int ITER          = WIDTH_DEFAULT / 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Partial-product selection for one radix-4 Booth digit
    typedef enum logic [2:0] {
        ZERO,
        PA,
        P2A,
        NA,
        N2A
    } booth_op_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: {b[2i+1], b[2i], b[2i-1]} -> partial-product op.
module booth_r4_encoder
    import mult_pkg::*;
(
    input  logic [2:0] triplet,
    output booth_op_t  op
);

    // Map the recoding triplet to a digit in {-2,-1,0,+1,+2}
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives op, so no latch is inferred.
        op = ZERO;
        case (triplet)
            3'b001, 3'b010: op = PA;
            3'b011:         op = P2A;
            3'b100:         op = N2A;
            3'b101, 3'b110: op = NA;
            default:        op = ZERO;
        endcase
    end

endmodule

// File: rtl/multiplier_core.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-4 Booth, WIDTH/2 iteration cycles.
// Returns the low WIDTH product bits, a one-cycle ready pulse and a signed
// overflow flag. Define MULT_PROD_HI_EN to also expose the upper product half
// on mult_result_hi.
module multiplier_core
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] mult_result,
    output logic             data_resultRDY,
    output logic             data_exception
`ifdef MULT_PROD_HI_EN
    ,
    output logic [WIDTH-1:0] mult_result_hi
`endif
);

    localparam int ITER_L = WIDTH / 2;
    localparam int CNT_W  = $clog2(ITER_L) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               b_m1_q;
    // Upper WIDTH+1 bits take the partial sums; lower WIDTH bits collect shifted-out product bits
    logic [2*WIDTH:0]   acc_q;
    logic [2*WIDTH:0]   acc_next;
    logic [WIDTH+1:0]   a_ext;
    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH-1:0] product;
    logic               overflow;
    logic               last_step;
    booth_op_t          op;
    logic               unused_low_bits;

    booth_r4_encoder u_encoder (
        .triplet ({b_q[1:0], b_m1_q}),
        .op      (op)
    );

    assign last_step = (state_q == RUN) && (count_q == CNT_W'(ITER_L - 1));

    // Next-state logic and the ready pulse, which is simply "sitting in DONE"
    always_comb begin
        state_d        = state_q;
        data_resultRDY = 1'b0;
        case (state_q)
            IDLE: if (ctrl_MULT) state_d = RUN;
            RUN: begin
                if (ctrl_MULT)      state_d = RUN;
                else if (last_step) state_d = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                state_d        = ctrl_MULT ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Step counter: cleared by reset or a new start, advanced once per RUN step
    always_ff @(posedge clock) begin
        if (!reset_n)            count_q <= '0;
        else if (ctrl_MULT)      count_q <= '0;
        else if (state_q == RUN) count_q <= count_q + CNT_W'(1);
    end

    // Select 0, +-A or +-2A, sign-extended to WIDTH+2 bits so 2A never wraps
    always_comb begin
        a_ext  = {{2{a_q[WIDTH-1]}}, a_q};
        addend = '0;
        case (op)
            PA:      addend = a_ext;
            P2A:     addend = a_ext << 1;
            NA:      addend = -a_ext;
            N2A:     addend = -(a_ext << 1);
            default: addend = '0;
        endcase
    end

    // Add into the upper half, then arithmetic-shift the whole accumulator right by 2.
    // The bits dropped off the bottom are the cleared initial zeros, never product bits.
    assign sum             = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH]} + addend;
    assign acc_next        = {sum[WIDTH+1], sum, acc_q[WIDTH-1:2]};
    assign product         = acc_next[2*WIDTH-1:0];
    assign overflow        = !((&product[2*WIDTH-1:WIDTH-1]) || (~|product[2*WIDTH-1:WIDTH-1]));
    assign unused_low_bits = ^acc_q[1:0];

    // Operand and accumulator datapath
    always_ff @(posedge clock) begin
        // NOTE: datapath registers carry no reset; they are always loaded by a start before being read.
        if (ctrl_MULT) begin
            a_q    <= multiplicand;
            b_q    <= multiplier;
            b_m1_q <= 1'b0;
            acc_q  <= '0;
        end else if (state_q == RUN) begin
            acc_q  <= acc_next;
            b_q    <= {2'b00, b_q[WIDTH-1:2]};
            b_m1_q <= b_q[1];
        end
    end

    // Result registers: load on entering DONE (unless restarted), hold otherwise
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mult_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULT_PROD_HI_EN
            mult_result_hi <= '0;
`endif
        end else if (last_step && !ctrl_MULT) begin
            mult_result    <= product[WIDTH-1:0];
            data_exception <= overflow;
`ifdef MULT_PROD_HI_EN
            mult_result_hi <= product[2*WIDTH-1:WIDTH];
`endif
        end
    end

endmodule

// File: tb/tb_multiplier_core.sv
// Self-checking bench for multiplier_core: directed corner cases, restart,
// mid-operation reset and randomized operands against a 64-bit arithmetic model.
module tb_multiplier_core;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         ctrl_MULT;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic [W-1:0] mult_result;
    logic         data_resultRDY;
    logic         data_exception;
`ifdef MULT_PROD_HI_EN
    logic [W-1:0] mult_result_hi;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] last_res;
    logic         last_exc;
`ifdef MULT_PROD_HI_EN
    logic [W-1:0] last_hi;
`endif

    multiplier_core #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .mult_result    (mult_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
`ifdef MULT_PROD_HI_EN
        ,
        .mult_result_hi (mult_result_hi)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: exact signed product in 64-bit arithmetic
    function automatic longint ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        return longint'(sa) * longint'(sb);
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = W'($urandom_range(0, 511)) - W'(256);
            2:       v = 32'h8000_0000;
            3:       v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            default: begin
                v = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) v = -v;
            end
        endcase
        return v;
    endfunction

    // Pulse ctrl_MULT for one edge, then scramble operands to prove they are not re-sampled
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_MULT    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        #1;
        ctrl_MULT    = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       p;
        logic [63:0]  pu;
        logic         exp_exc;
        int           lat;
        p       = ref_prod(a, b);
        pu      = p;
        exp_exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        start_op(a, b);
        check({tag, ".hold_res"}, 64'(mult_result), 64'(last_res));
        check({tag, ".hold_exc"}, 64'(data_exception), 64'(last_exc));
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        check({tag, ".latency"}, 64'(lat), 64'd16);
        check({tag, ".result"}, 64'(mult_result), 64'(pu[W-1:0]));
        check({tag, ".exc"}, 64'(data_exception), 64'(exp_exc));
`ifdef MULT_PROD_HI_EN
        check({tag, ".hi"}, 64'(mult_result_hi), 64'(pu[2*W-1:W]));
        last_hi = pu[2*W-1:W];
`endif
        @(posedge clock);
        #1;
        check({tag, ".rdy_pulse"}, 64'(data_resultRDY), 64'd0);
        check({tag, ".res_held"}, 64'(mult_result), 64'(pu[W-1:0]));
        last_res = pu[W-1:0];
        last_exc = exp_exc;
    endtask

    initial begin
        int rdy_cnt;
        int rdy_at;

        reset_n      = 1'b0;
        ctrl_MULT    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        last_res     = '0;
        last_exc     = 1'b0;
`ifdef MULT_PROD_HI_EN
        last_hi      = '0;
`endif
        repeat (2) @(posedge clock);
        #1;
        check("reset.res", 64'(mult_result), 64'd0);
        check("reset.rdy", 64'(data_resultRDY), 64'd0);
        check("reset.exc", 64'(data_exception), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op("t1_124xm34",   32'd124,        32'hFFFF_FFDE);
        run_op("t2_15x3",      32'd15,         32'd3);
        run_op("t2_10x5",      32'd10,         32'd5);
        run_op("t2_0xmax",     32'd0,          32'h7FFF_FFFF);
        run_op("t3_minxm1",    32'h8000_0000,  32'hFFFF_FFFF);
        run_op("t3_minx1",     32'h8000_0000,  32'd1);
        run_op("t3_2p16sq",    32'h0001_0000,  32'h0001_0000);
        run_op("t4_maxxm1",    32'h7FFF_FFFF,  32'hFFFF_FFFF);
        run_op("t4_m46341",    -32'sd46341,    32'd46341);
        run_op("t4_m46340",    -32'sd46340,    32'd46340);
        run_op("t4_minxmin",   32'h8000_0000,  32'h8000_0000);
        run_op("t4_maxx0",     32'h7FFF_FFFF,  32'd0);

        // Restart: second start at edge 5 of 7*6 must replace it entirely
        start_op(32'd7, 32'd6);
        repeat (4) @(posedge clock);
        #1;
        start_op(32'd3, 32'd3);
        rdy_cnt = 0;
        rdy_at  = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (rdy_at == 0) rdy_at = n;
            end
            if (n == 16) check("t5.result", 64'(mult_result), 64'd9);
        end
        check("t5.rdy_count", 64'(rdy_cnt), 64'd1);
        check("t5.rdy_at", 64'(rdy_at), 64'd16);
        last_res = 32'd9;
        last_exc = 1'b0;
`ifdef MULT_PROD_HI_EN
        last_hi  = '0;
`endif

        // Reset in the middle of an operation: outputs clear, no ready afterwards
        start_op(32'd100, 32'd200);
        repeat (7) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("t6.res", 64'(mult_result), 64'd0);
        check("t6.exc", 64'(data_exception), 64'd0);
        check("t6.rdy", 64'(data_resultRDY), 64'd0);
        reset_n = 1'b1;
        rdy_cnt = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        check("t6.no_rdy", 64'(rdy_cnt), 64'd0);
        last_res = '0;
        last_exc = 1'b0;
`ifdef MULT_PROD_HI_EN
        last_hi  = '0;
`endif
        run_op("t6_2xm2", 32'd2, 32'hFFFF_FFFE);

        // Randomized operands, including back-to-back and idle gaps
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
            run_op($sformatf("rand%0d", i), rand_operand(), rand_operand());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
